// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter.
// State and owner encodings plus the default abort timeout.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals of the arbiter.
// slave = arbiter view, master = requesters/memory view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              err;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata, mem_ready,
        output if_gnt, if_valid, if_rdata,
        output d_gnt, d_valid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output err
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata, mem_ready,
        input  if_gnt, if_valid, if_rdata,
        input  d_gnt, d_valid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  err
    );
endinterface

// File: rtl/mem_arbiter_timeout_cnt.sv
// BUSY-cycle counter; expired flags the last allowed BUSY cycle.
// Cleared on BUSY entry, saturates once expired.
module arb_timeout_cnt
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYC);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expired = (cnt_q == W'(TIMEOUT_CYC - 1));

    // Next count: clear wins, then count while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one memory port, IDLE/BUSY/DONE FSM.
// ARB_ROUND_ROBIN_EN: alternate ties; otherwise data wins ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);
    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            win;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              if_gnt_q, if_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              err_q, err_d;
    logic              clr;
    logic              expired;
`ifdef ARB_ROUND_ROBIN_EN
    owner_t            last_q, last_d;
`endif

    arb_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (clr),
        .enable  (state_q == BUSY),
        .expired (expired)
    );

    // Pick the winner among pending requests
    always_comb begin
        win = bus.d_req ? OWN_D : OWN_IF;
`ifdef ARB_ROUND_ROBIN_EN
        if (bus.if_req && bus.d_req) begin
            win = (last_q == OWN_IF) ? OWN_D : OWN_IF;
        end
`endif
    end

    // FSM next state and next registered outputs
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_gnt_d   = 1'b0;
        d_gnt_d    = 1'b0;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        err_d      = 1'b0;
        clr        = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (if_gnt_q || d_gnt_q) begin
                    state_d  = BUSY;
                    mem_en_d = 1'b1;
                    mem_we_d = we_q;
                    clr      = 1'b1;
                end else if (bus.if_req || bus.d_req) begin
                    owner_d = win;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = win;
`endif
                    if (win == OWN_D) begin
                        d_gnt_d = 1'b1;
                        we_d    = bus.d_we;
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                    end else begin
                        if_gnt_d = 1'b1;
                        we_d     = 1'b0;
                        addr_d   = bus.if_addr;
                        wdata_d  = '0;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ready || expired) begin
                    state_d = DONE;
                    err_d   = !bus.mem_ready;
                    if (owner_q == OWN_D) begin
                        d_valid_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
                    end
                end else begin
                    mem_en_d = 1'b1;
                    mem_we_d = we_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_gnt_q   <= 1'b0;
            d_gnt_q    <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            err_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= OWN_IF;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_gnt_q   <= if_gnt_d;
            d_gnt_q    <= d_gnt_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            err_q      <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter.
// Reference model tracks winner, latency and held read data.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

    mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    owner_t      m_last;
    logic [31:0] m_if_rd;
    logic [31:0] m_d_rd;
    bit          ifp;
    bit          dp;
    owner_t      seq [3];
    owner_t      exp_seq [3];
    owner_t      own;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic owner_t winner();
        if (ifp && dp) begin
`ifdef ARB_ROUND_ROBIN_EN
            return (m_last == OWN_IF) ? OWN_D : OWN_IF;
`else
            return OWN_D;
`endif
        end
        return dp ? OWN_D : OWN_IF;
    endfunction

    task automatic raise_if(input logic [31:0] a);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        ifp = 1'b1;
    endtask

    task automatic raise_d(input logic we, input logic [31:0] a,
                           input logic [31:0] wd);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        dp = 1'b1;
    endtask

    // One access: lat = BUSY cycle of mem_ready, 0 = never (timeout)
    task automatic txn(input int lat, input logic [31:0] rdv,
                       output owner_t o);
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          nb;
        o  = winner();
        we = (o == OWN_D) ? bus.d_we : 1'b0;
        a  = (o == OWN_D) ? bus.d_addr : bus.if_addr;
        wd = bus.d_wdata;
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        step();
        chk("if_gnt", 64'(bus.if_gnt), 64'(o == OWN_IF));
        chk("d_gnt", 64'(bus.d_gnt), 64'(o == OWN_D));
        chk("gnt_mem_en", 64'(bus.mem_en), 64'(0));
        m_last = o;
        nb = (lat == 0) ? TO : lat;
        rd = '0;
        for (int b = 1; b <= nb; b++) begin
            step();
            chk("busy_en", 64'(bus.mem_en), 64'(1));
            chk("busy_we", 64'(bus.mem_we), 64'(we));
            chk("busy_addr", 64'(bus.mem_addr), 64'(a));
            if (we) chk("busy_wdata", 64'(bus.mem_wdata), 64'(wd));
            chk("busy_pulse", 64'(bus.if_gnt | bus.d_gnt |
                bus.if_valid | bus.d_valid | bus.err), 64'(0));
            bus.mem_ready = (b == lat);
            bus.mem_rdata = (b == lat) ? rdv : $urandom;
            if (b == lat) rd = rdv;
        end
        step();
        if (!we) begin
            if (o == OWN_IF) m_if_rd = rd;
            else m_d_rd = rd;
        end
        chk("if_valid", 64'(bus.if_valid), 64'(o == OWN_IF));
        chk("d_valid", 64'(bus.d_valid), 64'(o == OWN_D));
        chk("err", 64'(bus.err), 64'(lat == 0));
        chk("if_rdata", 64'(bus.if_rdata), 64'(m_if_rd));
        chk("d_rdata", 64'(bus.d_rdata), 64'(m_d_rd));
        chk("done_en", 64'(bus.mem_en), 64'(0));
        chk("done_we", 64'(bus.mem_we), 64'(0));
        bus.mem_ready = 1'($urandom_range(0, 1));
        if (o == OWN_IF) begin
            bus.if_req = 1'b0;
            ifp = 1'b0;
        end else begin
            bus.d_req = 1'b0;
            dp = 1'b0;
        end
        step();
        chk("idle_pulse", 64'(bus.if_gnt | bus.d_gnt |
            bus.if_valid | bus.d_valid | bus.err), 64'(0));
        chk("idle_en", 64'(bus.mem_en), 64'(0));
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1);
    end

    initial begin
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        m_last  = OWN_IF;
        m_if_rd = '0;
        m_d_rd  = '0;
        ifp = 1'b0;
        dp  = 1'b0;

        step();
        step();
        chk("rst_gnt", 64'(bus.if_gnt | bus.d_gnt), 64'(0));
        chk("rst_valid", 64'(bus.if_valid | bus.d_valid), 64'(0));
        chk("rst_mem", 64'({bus.mem_en, bus.mem_we, bus.err}), 64'(0));
        chk("rst_addr", 64'(bus.mem_addr), 64'(0));
        chk("rst_if_rdata", 64'(bus.if_rdata), 64'(0));
        chk("rst_d_rdata", 64'(bus.d_rdata), 64'(0));
        reset = 1'b1;
        step();

        raise_if(32'h0000_0004);
        txn(1, 32'h8C02_0000, own);
        chk("fetch_rdata", 64'(bus.if_rdata), 64'(32'h8C02_0000));

        raise_d(1'b0, 32'h40, 32'h0);
        txn(2, 32'hA5A5_0001, own);

        raise_d(1'b1, 32'h10, 32'hDEAD_BEEF);
        txn(3, 32'h1234_5678, own);
        chk("store_keep", 64'(bus.d_rdata), 64'(32'hA5A5_0001));

        raise_d(1'b0, 32'h80, 32'h0);
        txn(0, 32'h0, own);
        chk("timeout_rdata", 64'(bus.d_rdata), 64'(0));

        raise_d(1'b0, 32'h20, 32'h0);
        step();
        chk("pre_rst_gnt", 64'(bus.d_gnt), 64'(1));
        step();
        chk("pre_rst_en", 64'(bus.mem_en), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_en", 64'(bus.mem_en), 64'(0));
        chk("rst_mid_rdata", 64'(bus.if_rdata | bus.d_rdata), 64'(0));
        m_last  = OWN_IF;
        m_if_rd = '0;
        m_d_rd  = '0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_no_valid", 64'(bus.d_valid | bus.if_valid), 64'(0));
            chk("rst_hold_en", 64'(bus.mem_en), 64'(0));
        end
        reset = 1'b1;
        raise_if(32'h100);

`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = '{OWN_D, OWN_IF, OWN_D};
`else
        exp_seq = '{OWN_D, OWN_D, OWN_D};
`endif
        for (int i = 0; i < 3; i++) begin
            if (!ifp) raise_if($urandom & 32'hFFFF_FFFC);
            if (!dp) raise_d(1'b0, $urandom, $urandom);
            txn(1, $urandom, seq[i]);
            chk("tie_order", 64'(seq[i]), 64'(exp_seq[i]));
        end

        for (int n = 0; n < 40; n++) begin
            int r;
            int lat;
            if (!ifp && $urandom_range(0, 1) == 1) raise_if($urandom);
            if (!dp && $urandom_range(0, 1) == 1)
                raise_d(1'($urandom_range(0, 1)), $urandom, $urandom);
            if (!ifp && !dp) raise_d(1'b0, $urandom, $urandom);
            r = $urandom_range(0, 7);
            lat = (r == 0) ? 0 : ((r % 4) + 1);
            txn(lat, $urandom, own);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 16, maximum BUSY cycles before abort (≥2).
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction-fetch request, held until if_valid.
- if_addr  in  ADDR_W  fetch address, stable while if_req.
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_valid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request, held until d_valid.
- d_we  in  1  1=store, 0=load; stable while d_req.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_valid  out  1  one-cycle pulse: access complete.
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completes current access this cycle.
- err  out  1  one-cycle pulse: access aborted by timeout.

Function
REQ-003 The block SHALL implement FSM states IDLE, BUSY, DONE; all outputs registered.
REQ-004 In IDLE, if any request is pending, the block SHALL latch the winner's address/we/wdata, pulse its gnt, and enter BUSY next cycle.
REQ-005 In BUSY the block SHALL hold mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values.
REQ-006 In BUSY with mem_ready=1 the block SHALL capture mem_rdata (loads/fetches only) and enter DONE.
REQ-007 In DONE the block SHALL pulse the owner's valid for exactly one cycle, drive mem_en=0, and return to IDLE.
REQ-008 The minimum latency SHALL be gnt at cycle N, valid at N+2 when mem_ready is asserted in the first BUSY cycle.
REQ-009 Stores SHALL leave d_rdata unchanged; if_rdata and d_rdata SHALL hold their last value between accesses.
REQ-010 A BUSY cycle counter SHALL reset on BUSY entry; if it reaches TIMEOUT_CYC without mem_ready, the block SHALL enter DONE with rdata=0, valid pulse and err pulse in the same cycle.
REQ-011 Requests arriving during BUSY/DONE SHALL wait; the IDLE cycle following DONE SHALL arbitrate them.
REQ-012 mem_ready outside BUSY SHALL be ignored.

Reset
REQ-013 reset low SHALL immediately force state IDLE and clear all outputs to 0, the counter, and the last-winner bit (=fetch), aborting any access in flight without a valid pulse.

Configuration
REQ-014 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester not granted last, and the last-winner bit SHALL update on every grant.
REQ-015 Without ARB_ROUND_ROBIN_EN, data SHALL always win ties over fetch, and the last-winner bit SHALL be absent.

Structure
REQ-016 The shared package mem_arbiter_pkg SHALL hold the state encoding (IDLE/BUSY/DONE), owner encoding (OWN_IF=0, OWN_D=1), and the default TIMEOUT_CYC.
REQ-017 The timeout counter SHALL be a sub-module named arb_timeout_cnt (inputs clear, enable; output expired).

Verification
REQ-018 The bench SHALL cover: if_req with addr 0x00000004 and mem_ready in the first BUSY cycle with mem_rdata 0x8C020000 -> if_gnt at N, mem_en at N+1, if_valid with if_rdata 0x8C020000 at N+2.
REQ-019 The bench SHALL cover: d_req with d_we=1, addr 0x10, wdata 0xDEADBEEF, and mem_ready after 3 cycles -> mem_we=1 for 3 cycles, d_valid one cycle, d_rdata unchanged.
REQ-020 The bench SHALL cover: if_req and d_req together for three consecutive accesses -> round-robin D, IF, D; fixed priority D, D, D while d_req held.
REQ-021 The bench SHALL cover: mem_ready never asserted with TIMEOUT_CYC=16 -> after 16 BUSY cycles, err and d_valid pulse together, d_rdata=0, FSM returns to IDLE.
REQ-022 The bench SHALL cover: reset low mid-BUSY -> mem_en=0 immediately, no valid pulse, and the first tie after release is granted to data.
